button_debouncer: RTL and testbench
===================================

// Module: button_debouncer
// PURPOSE
//   Debounces NUM_BTN raw push-button inputs for the digital lock.
//   - Sits directly downstream of clk_divider: consumes its divided_clk output as a sample strobe.
//   - Feeds clean levels and one-cycle press/release pulses to the lock FSM.
//   - Fully synchronous to clk_in. divided_clk is never used as a clock; only its rising edges are detected.
// PARAMETERS
//   NUM_BTN         4   number of independent button channels
//   STABLE_SAMPLES  3   consecutive differing samples required to flip a level (legal range 1..15)
//   CNT_W           4   width of each per-channel stability counter; must hold STABLE_SAMPLES
// PORTS
//   clk_in       in   1        system clock (25 MHz)
//   rst          in   1        reset, asynchronous, active-high
//   divided_clk  in   1        slow square wave from clk_divider, clk_in domain
//   btn_raw      in   NUM_BTN  raw asynchronous button inputs, 1 = pressed
//   btn_level    out  NUM_BTN  debounced level per channel, 1 = pressed
//   btn_press    out  NUM_BTN  1-clk_in-cycle pulse on a debounced 0->1 transition
//   btn_release  out  NUM_BTN  1-clk_in-cycle pulse on a debounced 1->0 transition
// BEHAVIOUR
//   Reset (async, rst=1):
//     - All registers clear: btn_level=0, btn_press=0, btn_release=0, counters=0, sync FFs=0, div_d=0.
//     - The block leaves reset on the first clk_in edge after rst falls.
//   Tick generation:
//     - div_d <= divided_clk each clk_in cycle.
//     - tick = divided_clk & ~div_d, so tick is high for exactly one cycle per divided_clk period.
//     - A divided_clk already high when reset is released produces one tick in the first cycle. This is allowed.
//   Input sync:
//     - Each btn_raw bit passes through a 2-FF synchronizer, giving s[i] 2 cycles after btn_raw.
//   Per-channel state (independent, identical):
//     - Per-channel 2-state FSM: RELEASED (btn_level=0) and PRESSED (btn_level=1). The state register is btn_level[i].
//     - State is evaluated only on cycles with tick=1. Between ticks, counters and levels hold.
//     - On a tick with s[i]==btn_level[i]: cnt[i] <= 0. Any glitch restarts the count.
//     - On a tick with s[i]!=btn_level[i] and cnt[i] < STABLE_SAMPLES-1: cnt[i] <= cnt[i]+1.
//     - On a tick with s[i]!=btn_level[i] and cnt[i] == STABLE_SAMPLES-1:
//       btn_level[i] toggles, cnt[i] <= 0, and the matching pulse is set.
//       A 0->1 toggle sets btn_press[i]; a 1->0 toggle sets btn_release[i].
//   Pulses:
//     - Registered. A pulse is high in the same cycle that the new btn_level is first visible.
//     - The pulse deasserts on the next cycle regardless of tick.
//     - btn_press[i] and btn_release[i] are never high together.
//     - Channels may pulse in the same cycle.
//   Latency:
//     - The level flips on the clk_in edge after the STABLE_SAMPLES-th consecutive differing tick.
//     - Worst case is 2 + STABLE_SAMPLES*Ttick + 1 clk_in cycles from a stable btn_raw change.
//   Boundaries:
//     - STABLE_SAMPLES=1: the level follows s[i] at every tick. No glitch filtering beyond tick sampling.
//     - A counter never exceeds STABLE_SAMPLES-1. No wrap-around.
//     - divided_clk held constant: no ticks, so outputs freeze at their current values.
//     - rst asserted mid-count or during a pulse: outputs go to 0 immediately and counts are lost.
//       A button held through reset produces a fresh press after STABLE_SAMPLES ticks.
// TESTING
//   (bench: STABLE_SAMPLES=3; divided_clk toggled every 4 clk_in cycles, giving a tick every 8 cycles)
//   1. btn_raw[0] 0->1 held -> btn_press[0] high exactly one cycle after the 3rd tick.
//      btn_level[0]=1 from that cycle. Other channels stay 0.
//   2. btn_raw[1] bounces 1,0,1,0 across ticks, then holds 1 for 3 ticks
//      -> no pulse during the bounce; one btn_press[1] after the 3rd stable tick.
//   3. btn_raw[2] held 1 until btn_level[2]=1, then released to 0
//      -> btn_release[2] single pulse after 3 ticks; btn_level[2]=0.
//   4. btn_raw=4'b1111 simultaneous -> btn_press=4'b1111 in the same cycle, each high for one cycle.
//   5. rst=1 pulse after the 2nd tick of a press -> all outputs 0 at once.
//      After release, with the button still held -> btn_press after 3 further ticks (not 1).
//   6. divided_clk stuck at 0 with btn_raw=4'b0101 held 100 cycles -> btn_level stays 0 and no pulses.
//      Restart divided_clk -> presses appear on channels 0 and 2 after 3 ticks.

Source files
------------

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - tick-sampled multi-channel push-button debouncer
//
// Purpose:
//   Cleans up NUM_BTN raw push-button inputs for the digital lock. The slow
//   square wave from clk_divider is edge-detected in the clk_in domain and
//   used only as a sample strobe (tick); it never clocks any flop. Each
//   channel flips its debounced level after STABLE_SAMPLES consecutive ticks
//   on which the synchronized input disagrees with the current level, and
//   emits a one-cycle press or release pulse alongside the new level.
//
// Parameters:
//   NUM_BTN         number of independent button channels
//   STABLE_SAMPLES  consecutive differing ticks needed to flip a level (1..15)
//   CNT_W           width of each per-channel stability counter
//
// Ports:
//   clk_in       in   1        system clock
//   rst          in   1        asynchronous active-high reset
//   divided_clk  in   1        slow square wave, clk_in domain, sampled only
//   btn_raw      in   NUM_BTN  raw asynchronous buttons, 1 = pressed
//   btn_level    out  NUM_BTN  debounced level per channel, 1 = pressed
//   btn_press    out  NUM_BTN  one-cycle pulse on a debounced 0->1 change
//   btn_release  out  NUM_BTN  one-cycle pulse on a debounced 1->0 change

module button_debouncer #(
  parameter int NUM_BTN        = 4,
  parameter int STABLE_SAMPLES = 3,
  parameter int CNT_W          = 4
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               divided_clk,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release
);

  // Counter value on which the next differing tick flips the level.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_SAMPLES - 1);

  // The channel state register doubles as the debounced level.
  typedef enum logic {
    ST_RELEASED = 1'b0,
    ST_PRESSED  = 1'b1
  } state_t;

  // ---------------------------------------------------------------------
  // Sample strobe: rising edge of divided_clk, one clk_in cycle wide.
  // A divided_clk already high when reset is released yields one tick in
  // the first cycle because div_d restarts at 0; that is harmless.
  // ---------------------------------------------------------------------
  logic div_d;
  logic tick;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      div_d <= 1'b0;
    end else begin
      div_d <= divided_clk;
    end
  end

  assign tick = divided_clk & ~div_d;

  // ---------------------------------------------------------------------
  // Two-flop synchronizers for the asynchronous button inputs.
  // ---------------------------------------------------------------------
  logic [NUM_BTN-1:0] sync_q1;
  logic [NUM_BTN-1:0] sync_q2;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
    end
  end

  // ---------------------------------------------------------------------
  // Per-channel debounce FSM, identical and independent per button.
  // ---------------------------------------------------------------------
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             press_q;
    logic             press_d;
    logic             release_q;
    logic             release_d;
    logic             differ;
    logic             flip;

    assign differ = (sync_q2[i] != logic'(state_q));

    // The >= keeps a flip reachable even if the counter were ever corrupted
    // past the terminal value; in normal operation it never exceeds it.
    assign flip = tick && differ && (cnt_q >= CNT_LAST);

    // State register: level, stability counter and registered pulses.
    always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
        state_q   <= ST_RELEASED;
        cnt_q     <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    // Next state: only ticks move anything. An agreeing sample restarts
    // the count, so any glitch inside the window costs a full new window.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (tick) begin
        if (!differ) begin
          cnt_d = '0;
        end else if (flip) begin
          cnt_d   = '0;
          state_d = (state_q == ST_RELEASED) ? ST_PRESSED : ST_RELEASED;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    // Outputs: pulses are registered on the same edge as the new level, so
    // they line up with it and drop one cycle later (flip cannot repeat
    // because the level then agrees with the sample).
    always_comb begin
      press_d   = 1'b0;
      release_d = 1'b0;
      if (flip) begin
        press_d   = (state_q == ST_RELEASED);
        release_d = (state_q == ST_PRESSED);
      end
    end

    assign btn_level[i]   = (state_q == ST_PRESSED);
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;
  end : g_chan

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - directed table-driven bench for button_debouncer

module tb_button_debouncer;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       divided_clk;
  logic [3:0] btn_raw;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic [3:0] btn_release;

  always #5 clk_in = ~clk_in;

  button_debouncer #(
    .NUM_BTN(4),
    .STABLE_SAMPLES(3),
    .CNT_W(4)
  ) dut (
    .clk_in(clk_in),
    .rst(rst),
    .divided_clk(divided_clk),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release)
  );

  int         total = 0;
  int         bad = 0;
  bit         div_run = 1'b0;
  int         div_cnt = 0;
  bit         tick_pending = 1'b0;
  logic [3:0] cur_level = 4'b0000;

  typedef struct {
    logic [3:0] raw;
    int         ticks;
    logic [3:0] level;
    logic [3:0] press;
    logic [3:0] rel;
  } vec_t;

  localparam int NVEC = 17;
  vec_t tbl [NVEC];

  task automatic check4(input string name, input logic [3:0] got, input logic [3:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  // One clk_in cycle; reports whether the edge just taken was a tick edge
  // (divided_clk was raised by the bench in the previous cycle).
  task automatic step(output bit was_tick);
    @(posedge clk_in);
    was_tick     = tick_pending;
    tick_pending = 1'b0;
    #1;
    if (div_run) begin
      div_cnt++;
      if (div_cnt == 4) begin
        div_cnt = 0;
        if (!divided_clk) tick_pending = 1'b1;
        divided_clk = ~divided_clk;
      end
    end
  endtask

  // Apply raw, run until the requested number of tick edges, check outputs
  // right after the last one, then check the pulses drop a cycle later.
  task automatic run_vec(input string name, input vec_t v);
    bit t;
    bit quiet = 1'b1;
    int seen = 0;
    int budget = 12 * v.ticks + 4;
    btn_raw = v.raw;
    while (seen < v.ticks && budget > 0) begin
      step(t);
      budget--;
      if (t) seen++;
      if (seen < v.ticks) begin
        if (btn_level !== cur_level || btn_press !== 4'b0000 || btn_release !== 4'b0000)
          quiet = 1'b0;
      end
    end
    total++;
    if (!quiet || seen < v.ticks) begin
      bad++;
      $display("FAIL %s.quiet: ticks %0d want %0d, quiet %0b want 1", name, seen, v.ticks, quiet);
    end
    check4({name, ".level"}, btn_level, v.level);
    check4({name, ".press"}, btn_press, v.press);
    check4({name, ".release"}, btn_release, v.rel);
    step(t);
    check4({name, ".press_drop"}, btn_press, 4'b0000);
    check4({name, ".release_drop"}, btn_release, 4'b0000);
    check4({name, ".level_hold"}, btn_level, v.level);
    cur_level = v.level;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit t;
    bit quiet;

    //              raw      ticks level    press    release
    tbl[0]  = '{4'b0001, 3, 4'b0001, 4'b0001, 4'b0000};  // single press ch0
    tbl[1]  = '{4'b0011, 1, 4'b0001, 4'b0000, 4'b0000};  // ch1 bounce
    tbl[2]  = '{4'b0001, 1, 4'b0001, 4'b0000, 4'b0000};
    tbl[3]  = '{4'b0011, 1, 4'b0001, 4'b0000, 4'b0000};
    tbl[4]  = '{4'b0001, 1, 4'b0001, 4'b0000, 4'b0000};
    tbl[5]  = '{4'b0011, 3, 4'b0011, 4'b0010, 4'b0000};  // ch1 stable press
    tbl[6]  = '{4'b0111, 3, 4'b0111, 4'b0100, 4'b0000};  // ch2 press
    tbl[7]  = '{4'b0011, 2, 4'b0111, 4'b0000, 4'b0000};  // ch2 release pending
    tbl[8]  = '{4'b0011, 1, 4'b0011, 4'b0000, 4'b0100};  // ch2 release
    tbl[9]  = '{4'b0000, 3, 4'b0000, 4'b0000, 4'b0011};  // two releases together
    tbl[10] = '{4'b1111, 3, 4'b1111, 4'b1111, 4'b0000};  // all pressed at once
    tbl[11] = '{4'b0000, 3, 4'b0000, 4'b0000, 4'b1111};  // all released at once
    tbl[12] = '{4'b0001, 2, 4'b0000, 4'b0000, 4'b0000};  // count to 2
    tbl[13] = '{4'b0000, 1, 4'b0000, 4'b0000, 4'b0000};  // glitch restarts count
    tbl[14] = '{4'b0001, 2, 4'b0000, 4'b0000, 4'b0000};  // 2 again: still no flip
    tbl[15] = '{4'b0001, 1, 4'b0001, 4'b0001, 4'b0000};  // third tick flips
    tbl[16] = '{4'b0000, 3, 4'b0000, 4'b0000, 4'b0001};

    rst         = 1'b1;
    divided_clk = 1'b0;
    btn_raw     = 4'b0000;
    step(t);
    step(t);
    check4("reset.level", btn_level, 4'b0000);
    check4("reset.press", btn_press, 4'b0000);
    check4("reset.release", btn_release, 4'b0000);
    rst     = 1'b0;
    div_run = 1'b1;

    run_vec("align", '{4'b0000, 1, 4'b0000, 4'b0000, 4'b0000});

    for (int i = 0; i < NVEC; i++) begin
      run_vec($sformatf("vec%0d", i), tbl[i]);
    end

    // Reset in the middle of a count, with another channel already pressed.
    run_vec("rst_pre0", '{4'b1000, 3, 4'b1000, 4'b1000, 4'b0000});
    run_vec("rst_pre1", '{4'b1001, 2, 4'b1000, 4'b0000, 4'b0000});
    rst = 1'b1;
    #1;
    check4("rst_async.level", btn_level, 4'b0000);
    check4("rst_async.press", btn_press, 4'b0000);
    check4("rst_async.release", btn_release, 4'b0000);
    step(t);
    step(t);
    for (int k = 0; k < 10 && divided_clk; k++) step(t);
    check4("rst_hold.level", btn_level, 4'b0000);
    rst       = 1'b0;
    cur_level = 4'b0000;
    run_vec("rst_post0", '{4'b1001, 2, 4'b0000, 4'b0000, 4'b0000});
    run_vec("rst_post1", '{4'b1001, 1, 4'b1001, 4'b1001, 4'b0000});
    run_vec("rst_post2", '{4'b0000, 3, 4'b0000, 4'b0000, 4'b1001});

    // Frozen divided_clk: no ticks, so nothing may move.
    for (int k = 0; k < 10 && divided_clk; k++) step(t);
    div_run = 1'b0;
    div_cnt = 0;
    btn_raw = 4'b0101;
    quiet   = 1'b1;
    for (int k = 0; k < 100; k++) begin
      step(t);
      if (btn_level !== 4'b0000 || btn_press !== 4'b0000 || btn_release !== 4'b0000)
        quiet = 1'b0;
    end
    total++;
    if (!quiet) begin
      bad++;
      $display("FAIL freeze.quiet: outputs moved (level %b) want 0000 with no pulses", btn_level);
    end
    div_run = 1'b1;
    run_vec("restart", '{4'b0101, 3, 4'b0101, 4'b0101, 4'b0000});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
